regfile_clr_bypass: RTL and testbench

//  Parametrised 2-read/1-write register file for the Gumnut datapath, next generation of the core regfile.

---
 rtl/regfile_clr_bypass.sv | 108 ++++++++++
 tb/tb_regfile_clr_bypass.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_clr_bypass.sv
// 2-read/1-write register file with registered reads, write-to-read bypass and a sequenced clear sweep.
// Reads land one enabled edge after the address; writes are ignored while o_busy is high; i_cen=0 freezes everything.
module regfile_clr_bypass #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cen,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [DATA_W-1:0] i_dat,
  input  logic [ADDR_W-1:0] i_rs,
  input  logic [ADDR_W-1:0] i_rs2,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_rs,
  output logic [DATA_W-1:0] o_rs2,
  output logic              o_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_rs;
  logic [DATA_W-1:0] r_rs2;
  logic              r_busy;

  logic              w_wr_ok;
  logic              w_wr_en;
  logic              w_last;
  logic [DATA_W-1:0] w_rs_nxt;
  logic [DATA_W-1:0] w_rs2_nxt;

  // A write dropped by a clear request must not be forwarded either.
  always_comb begin
    w_wr_ok = i_we && !((ZERO_REG != 0) && (i_rd == '0));
    w_wr_en = (r_state == S_IDLE) && !i_clr && w_wr_ok;
    w_last  = (r_ptr == ADDR_W'(DEPTH - 1));

    if ((ZERO_REG != 0) && (i_rs == '0))
      w_rs_nxt = '0;
    else if ((BYPASS != 0) && w_wr_en && (i_rd == i_rs))
      w_rs_nxt = i_dat;
    else
      w_rs_nxt = r_mem[i_rs];

    if ((ZERO_REG != 0) && (i_rs2 == '0))
      w_rs2_nxt = '0;
    else if ((BYPASS != 0) && w_wr_en && (i_rd == i_rs2))
      w_rs2_nxt = i_dat;
    else
      w_rs2_nxt = r_mem[i_rs2];
  end

  // Array is never reset directly; the clear sweep zeroes it.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_cen) begin
      if (r_state == S_CLEAR)
        r_mem[r_ptr] <= '0;
      else if (w_wr_en)
        r_mem[i_rd] <= i_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
      r_rs    <= '0;
      r_rs2   <= '0;
      r_busy  <= 1'b1;
    end else if (i_cen) begin
      if (r_state == S_CLEAR) begin
        r_rs  <= '0;
        r_rs2 <= '0;
        if (i_clr) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= r_ptr + ADDR_W'(1);
          if (w_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
      end else begin
        r_rs  <= w_rs_nxt;
        r_rs2 <= w_rs2_nxt;
        if (i_clr) begin
          r_state <= S_CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      end
    end
  end

  assign o_rs   = r_rs;
  assign o_rs2  = r_rs2;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_regfile_clr_bypass.sv
// Drives three regfile variants from one stimulus stream and checks them against an array-level model.
module tb_regfile_clr_bypass;

  logic        clk;
  logic        rst, cen, we, clr;
  logic [3:0]  rd, rs, rs2;
  logic [15:0] dat;

  logic [7:0]  o_rs_0, o_rs2_0, o_rs_1, o_rs2_1;
  logic [15:0] o_rs_2, o_rs2_2;
  logic        o_busy_0, o_busy_1, o_busy_2;

  int total = 0;
  int bad   = 0;

  // u0: plain with bypass; u1: hardwired r0, no bypass; u2: wide and deep with bypass.
  regfile_clr_bypass #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_cen(cen), .i_we(we), .i_rd(rd[2:0]), .i_dat(dat[7:0]),
    .i_rs(rs[2:0]), .i_rs2(rs2[2:0]), .i_clr(clr), .o_rs(o_rs_0), .o_rs2(o_rs2_0), .o_busy(o_busy_0));
  regfile_clr_bypass #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_cen(cen), .i_we(we), .i_rd(rd[2:0]), .i_dat(dat[7:0]),
    .i_rs(rs[2:0]), .i_rs2(rs2[2:0]), .i_clr(clr), .o_rs(o_rs_1), .o_rs2(o_rs2_1), .o_busy(o_busy_1));
  regfile_clr_bypass #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u2 (
    .i_clk(clk), .i_rst(rst), .i_cen(cen), .i_we(we), .i_rd(rd), .i_dat(dat),
    .i_rs(rs), .i_rs2(rs2), .i_clr(clr), .o_rs(o_rs_2), .o_rs2(o_rs2_2), .o_busy(o_busy_2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A clear is observable only as "busy for DEPTH enabled edges, then all zero",
  // so the model zeroes the whole array at once and just counts busy edges.
  logic [15:0] m_mem [3][16];
  bit          m_busy [3];
  int          m_left [3];
  logic [15:0] m_rs [3];
  logic [15:0] m_rs2 [3];
  bit          m_valid = 1'b0;

  function automatic logic [3:0] amask(int k);
    return (k == 2) ? 4'hF : 4'h7;
  endfunction
  function automatic logic [15:0] dmask(int k);
    return (k == 2) ? 16'hFFFF : 16'h00FF;
  endfunction
  function automatic int depth_of(int k);
    return (k == 2) ? 16 : 8;
  endfunction
  function automatic bit zr(int k);
    return k == 1;
  endfunction
  function automatic bit bp(int k);
    return k != 1;
  endfunction

  function automatic logic [15:0] mread(int k, logic [3:0] a, bit fwd, logic [3:0] wa, logic [15:0] wd);
    if (zr(k) && a == 4'd0) return 16'h0000;
    if (fwd && a == wa) return wd;
    return m_mem[k][a];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [3:0]  wa, ra, rb;
      logic [15:0] wd;
      bit          wok;
      wa  = rd & amask(k);
      ra  = rs & amask(k);
      rb  = rs2 & amask(k);
      wd  = dat & dmask(k);
      wok = we && !(zr(k) && wa == 4'd0);
      if (rst) begin
        m_valid   = 1'b1;
        m_busy[k] = 1'b1;
        m_left[k] = depth_of(k);
        m_rs[k]   = 16'h0;
        m_rs2[k]  = 16'h0;
        for (int j = 0; j < 16; j++) m_mem[k][j] = 16'h0;
      end else if (cen) begin
        if (m_busy[k]) begin
          m_rs[k]  = 16'h0;
          m_rs2[k] = 16'h0;
          if (clr) m_left[k] = depth_of(k);
          else begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) m_busy[k] = 1'b0;
          end
        end else if (clr) begin
          m_rs[k]   = mread(k, ra, 1'b0, wa, wd);
          m_rs2[k]  = mread(k, rb, 1'b0, wa, wd);
          m_busy[k] = 1'b1;
          m_left[k] = depth_of(k);
          for (int j = 0; j < 16; j++) m_mem[k][j] = 16'h0;
        end else begin
          m_rs[k]  = mread(k, ra, bp(k) && wok, wa, wd);
          m_rs2[k] = mread(k, rb, bp(k) && wok, wa, wd);
          if (wok) m_mem[k][wa] = wd;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Hand-computed value: pins both the DUT and the model.
  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] mdl, input logic [15:0] exp);
    check(name, act, exp);
    check({name, "_model"}, mdl, exp);
  endtask

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("u0_rs",   {8'h00, o_rs_0},  m_rs[0]);
      check("u0_rs2",  {8'h00, o_rs2_0}, m_rs2[0]);
      check("u0_busy", {15'h0, o_busy_0}, {15'h0, m_busy[0]});
      check("u1_rs",   {8'h00, o_rs_1},  m_rs[1]);
      check("u1_rs2",  {8'h00, o_rs2_1}, m_rs2[1]);
      check("u1_busy", {15'h0, o_busy_1}, {15'h0, m_busy[1]});
      check("u2_rs",   o_rs_2,  m_rs[2]);
      check("u2_rs2",  o_rs2_2, m_rs2[2]);
      check("u2_busy", {15'h0, o_busy_2}, {15'h0, m_busy[2]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    rst = 0; cen = 1; we = 0; clr = 0; rd = 0; dat = 0;
  endtask

  initial begin
    rst = 1; cen = 0; we = 0; clr = 0; rd = 0; dat = 0; rs = 0; rs2 = 0;
    // T1: reset (overrides cen) then the sweep
    tick();
    lit("t1_busy_rst", {15'h0, o_busy_0}, {15'h0, m_busy[0]}, 16'h0001);
    lit("t1_rs_rst", {8'h0, o_rs_0}, m_rs[0], 16'h0000);
    idle_in();
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 7)  lit("t1_busy7",  {15'h0, o_busy_0}, {15'h0, m_busy[0]}, 16'h0001);
      if (i == 8)  lit("t1_busy8",  {15'h0, o_busy_0}, {15'h0, m_busy[0]}, 16'h0000);
      if (i == 15) lit("t6_busy15", {15'h0, o_busy_2}, {15'h0, m_busy[2]}, 16'h0001);
      if (i == 16) lit("t6_busy16", {15'h0, o_busy_2}, {15'h0, m_busy[2]}, 16'h0000);
    end
    for (int a = 0; a < 8; a++) begin
      rs = 4'(a); rs2 = 4'(7 - a);
      tick();
    end
    lit("t1_read_r0", {8'h0, o_rs2_0}, m_rs2[0], 16'h0000);

    // T2: write then read on both ports
    we = 1; rd = 3; dat = 16'h00A5; rs = 0; rs2 = 0;
    tick();
    we = 0; rs = 3; rs2 = 3;
    tick();
    lit("t2_rs",  {8'h0, o_rs_0},  m_rs[0],  16'h00A5);
    lit("t2_rs2", {8'h0, o_rs2_0}, m_rs2[0], 16'h00A5);
    lit("t2_u1",  {8'h0, o_rs_1},  m_rs[1],  16'h00A5);
    rs = 2;
    tick();
    lit("t2_r2", {8'h0, o_rs_0}, m_rs[0], 16'h0000);

    // T3: bypass vs. no bypass
    we = 1; rd = 5; dat = 16'h003C; rs = 5;
    tick();
    lit("t3_byp",   {8'h0, o_rs_0}, m_rs[0], 16'h003C);
    lit("t3_nobyp", {8'h0, o_rs_1}, m_rs[1], 16'h0000);
    lit("t3_wide",  o_rs_2, m_rs[2], 16'h003C);
    we = 0;
    tick();
    lit("t3_nobyp_next", {8'h0, o_rs_1}, m_rs[1], 16'h003C);

    // T4: hardwired register 0
    we = 1; rd = 0; dat = 16'h00FF; rs = 0; rs2 = 0;
    tick();
    we = 0;
    tick();
    lit("t4_zero_rs",  {8'h0, o_rs_1},  m_rs[1],  16'h0000);
    lit("t4_zero_rs2", {8'h0, o_rs2_1}, m_rs2[1], 16'h0000);
    lit("t4_plain_r0", {8'h0, o_rs_0},  m_rs[0],  16'h00FF);

    // T5: cen=0 freezes everything, then a clear with a coincident write
    we = 1; rd = 1; dat = 16'h0011;
    tick();
    cen = 0; we = 1; rd = 1; dat = 16'h0022; clr = 1; rs = 1;
    tick();
    lit("t5_hold_busy", {15'h0, o_busy_0}, {15'h0, m_busy[0]}, 16'h0000);
    lit("t5_hold_rs",   {8'h0, o_rs_0},    m_rs[0],            16'h00FF);
    cen = 1; we = 0; clr = 0;
    tick();
    lit("t5_r1", {8'h0, o_rs_0}, m_rs[0], 16'h0011);
    clr = 1; we = 1; rd = 6; dat = 16'h0066; rs = 6;
    tick();
    lit("t5_clr_busy", {15'h0, o_busy_0}, {15'h0, m_busy[0]}, 16'h0001);
    clr = 0; we = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 7) lit("t5_busy7", {15'h0, o_busy_0}, {15'h0, m_busy[0]}, 16'h0001);
      if (i == 8) lit("t5_busy8", {15'h0, o_busy_0}, {15'h0, m_busy[0]}, 16'h0000);
    end
    rs = 6; rs2 = 1;
    tick();
    lit("t5_r6", {8'h0, o_rs_0},  m_rs[0],  16'h0000);
    lit("t5_r1_clr", {8'h0, o_rs2_0}, m_rs2[0], 16'h0000);

    // Clear request during a sweep restarts it
    clr = 1;
    tick();
    clr = 0;
    repeat (3) tick();
    clr = 1;
    tick();
    clr = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 7) lit("restart_busy7", {15'h0, o_busy_0}, {15'h0, m_busy[0]}, 16'h0001);
      if (i == 8) lit("restart_busy8", {15'h0, o_busy_0}, {15'h0, m_busy[0]}, 16'h0000);
    end

    // T6: reset at sweep pointer 9 on the wide variant
    clr = 1;
    tick();
    clr = 0;
    repeat (9) tick();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) lit("t6_rst_busy15", {15'h0, o_busy_2}, {15'h0, m_busy[2]}, 16'h0001);
      if (i == 16) lit("t6_rst_busy16", {15'h0, o_busy_2}, {15'h0, m_busy[2]}, 16'h0000);
    end
    we = 1; rd = 15; dat = 16'hBEEF; rs = 0; rs2 = 0;
    tick();
    we = 0; rs = 15; rs2 = 15;
    tick();
    lit("t6_beef", o_rs_2, m_rs[2], 16'hBEEF);
    lit("t6_r7_8bit", {8'h0, o_rs_0}, m_rs[0], 16'h00EF);

    // Mixed traffic with stalls and a late clear, checked by the model only
    for (int i = 0; i < 40; i++) begin
      cen = (i % 5) != 4;
      we  = (i % 3) != 0;
      rd  = 4'(i * 5);
      dat = 16'(i * 16'h1357);
      rs  = 4'(i * 3);
      rs2 = 4'(i * 7);
      clr = (i == 30);
      tick();
    end
    idle_in();
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
